// File: rtl/bp_stall_histogram.sv
// Stall-reason histogram: registers the per-cycle profiler stream, keeps one
// saturating counter per reason bin plus commit and cycle counters, and serves
// a shadow snapshot through a single-outstanding read handshake.
module bp_stall_histogram #(
   parameter int unsigned counter_width_p = 32,
   parameter int unsigned num_reasons_p   = 32
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       en_i,
   input  logic                       commit_v_i,
   input  logic                       stall_v_i,
   input  logic [4:0]                 stall_reason_i,
   input  logic                       clear_i,
   input  logic                       snapshot_i,
   input  logic                       rd_v_i,
   input  logic [5:0]                 rd_addr_i,
   output logic                       rd_ready_o,
   output logic                       rd_v_o,
   output logic [counter_width_p-1:0] rd_data_o,
   input  logic                       rd_yumi_i,
   output logic                       overflow_o,
   output logic                       illegal_o
);

   // Counter file layout: reason bins, then commit, then cycle.
   localparam int unsigned num_cnt_lp    = num_reasons_p + 2;
   localparam int unsigned commit_idx_lp = num_reasons_p;
   localparam int unsigned cycle_idx_lp  = num_reasons_p + 1;

   localparam logic [counter_width_p-1:0] cnt_max_lp = '1;
   localparam logic [counter_width_p-1:0] cnt_one_lp = counter_width_p'(1);

   typedef enum logic [0:0] {StIdle, StResp} state_t;

   logic       en_q;
   logic       commit_q;
   logic       stall_q;
   logic [4:0] reason_q;

   logic [num_cnt_lp-1:0]      inc;
   logic                       illegal_evt;
   logic                       sat_hit;
   logic [counter_width_p-1:0] applied  [num_cnt_lp];
   logic [counter_width_p-1:0] live_q   [num_cnt_lp];
   logic [counter_width_p-1:0] shadow_q [num_cnt_lp];
   logic                       overflow_q;
   logic                       illegal_q;

   logic [counter_width_p-1:0] rd_sel;
   logic [counter_width_p-1:0] rd_data_d, rd_data_q;
   state_t                     state_d, state_q;

   // Stage 1: register the incoming event stream.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         en_q     <= 1'b0;
         commit_q <= 1'b0;
         stall_q  <= 1'b0;
         reason_q <= '0;
      end else begin
         en_q     <= en_i;
         commit_q <= commit_v_i;
         stall_q  <= stall_v_i;
         reason_q <= stall_reason_i;
      end
   end

   // Classify the registered event into a one-hot increment per counter.
   always_comb begin
      inc         = '0;
      illegal_evt = 1'b0;
      if (en_q) begin
         inc[cycle_idx_lp] = 1'b1;
         if (commit_q) begin
            inc[commit_idx_lp] = 1'b1;
         end else if (stall_q) begin
            // Reserved code 31 is folded into the unknown bin.
            if (reason_q == 5'd31) begin
               inc[0]      = 1'b1;
               illegal_evt = 1'b1;
            end else begin
               inc[{1'b0, reason_q}] = 1'b1;
            end
         end
      end
   end

   // Saturating increment; the result feeds both the live and shadow banks.
   always_comb begin
      sat_hit = 1'b0;
      for (int unsigned i = 0; i < num_cnt_lp; i++) begin
         applied[i] = live_q[i];
         if (inc[i]) begin
            if (live_q[i] == cnt_max_lp) begin
               sat_hit = 1'b1;
            end else begin
               applied[i] = live_q[i] + cnt_one_lp;
            end
         end
      end
   end

   // Stage 2: live/shadow banks; clear drops the in-flight event from live only.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < num_cnt_lp; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < num_cnt_lp; i++) begin
            live_q[i] <= clear_i ? '0 : applied[i];
            if (snapshot_i) begin
               shadow_q[i] <= applied[i];
            end
         end
      end
   end

   // Sticky status flags.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (clear_i) begin
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         overflow_q <= overflow_q | sat_hit;
         illegal_q  <= illegal_q | illegal_evt;
      end
   end

   assign overflow_o = overflow_q;
   assign illegal_o  = illegal_q;

   // Read mux over the shadow bank; reserved addresses return zero.
   always_comb begin
      rd_sel = '0;
      if (rd_addr_i < 6'(num_cnt_lp)) begin
         rd_sel = shadow_q[rd_addr_i];
      end
   end

   // Read FSM state and response data registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= StIdle;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Read FSM next-state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      rd_data_d  = rd_data_q;
      rd_ready_o = 1'b0;
      rd_v_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            rd_ready_o = 1'b1;
            if (rd_v_i) begin
               rd_data_d = rd_sel;
               state_d   = StResp;
            end
         end
         StResp: begin
            rd_v_o = 1'b1;
            if (rd_yumi_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Self-checking bench for bp_stall_histogram with an 8-bit counter width so
// saturation is reachable; expectations come from an event-level model.
module tb_bp_stall_histogram;

   localparam int unsigned cw_lp  = 8;
   localparam int unsigned max_lp = 255;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             en_i = 1'b0;
   logic             commit_v_i = 1'b0;
   logic             stall_v_i = 1'b0;
   logic [4:0]       stall_reason_i = '0;
   logic             clear_i = 1'b0;
   logic             snapshot_i = 1'b0;
   logic             rd_v_i = 1'b0;
   logic [5:0]       rd_addr_i = '0;
   logic             rd_ready_o;
   logic             rd_v_o;
   logic [cw_lp-1:0] rd_data_o;
   logic             rd_yumi_i = 1'b0;
   logic             overflow_o;
   logic             illegal_o;

   int errors = 0;
   int checks = 0;

   // Reference model: live/shadow counts, sticky flags, and the one event
   // that has been sampled but not yet applied.
   int unsigned m_live   [34];
   int unsigned m_shadow [34];
   bit          m_ovf, m_ill;
   bit          p_en, p_commit, p_stall;
   int unsigned p_reason;

   bp_stall_histogram #(.counter_width_p(cw_lp), .num_reasons_p(32)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .en_i           (en_i),
      .commit_v_i     (commit_v_i),
      .stall_v_i      (stall_v_i),
      .stall_reason_i (stall_reason_i),
      .clear_i        (clear_i),
      .snapshot_i     (snapshot_i),
      .rd_v_i         (rd_v_i),
      .rd_addr_i      (rd_addr_i),
      .rd_ready_o     (rd_ready_o),
      .rd_v_o         (rd_v_o),
      .rd_data_o      (rd_data_o),
      .rd_yumi_i      (rd_yumi_i),
      .overflow_o     (overflow_o),
      .illegal_o      (illegal_o)
   );

   always #5 aclk = ~aclk;

   task automatic model_reset();
      for (int i = 0; i < 34; i++) begin
         m_live[i]   = 0;
         m_shadow[i] = 0;
      end
      m_ovf = 0; m_ill = 0;
      p_en = 0; p_commit = 0; p_stall = 0; p_reason = 0;
   endtask

   // One clock edge of the model: apply the previous cycle's event, then
   // honour snapshot/clear, then remember this cycle's inputs.
   task automatic model_step();
      int unsigned nxt [34];
      bit sat, ill;
      int tgt;
      nxt = m_live; sat = 0; ill = 0; tgt = -1;
      if (p_en) begin
         if (p_commit) tgt = 32;
         else if (p_stall) begin
            if (p_reason == 31) begin tgt = 0; ill = 1; end
            else tgt = int'(p_reason);
         end
         if (tgt >= 0) begin
            if (nxt[tgt] == max_lp) sat = 1; else nxt[tgt]++;
         end
         if (nxt[33] == max_lp) sat = 1; else nxt[33]++;
      end
      if (snapshot_i) m_shadow = nxt;
      if (clear_i) begin
         for (int i = 0; i < 34; i++) m_live[i] = 0;
         m_ovf = 0; m_ill = 0;
      end else begin
         m_live = nxt;
         m_ovf  = m_ovf | sat;
         m_ill  = m_ill | ill;
      end
      p_en = en_i; p_commit = commit_v_i; p_stall = stall_v_i; p_reason = stall_reason_i;
   endtask

   // Advance one cycle; inputs change and outputs are sampled on negedge.
   task automatic tick();
      @(posedge aclk);
      model_step();
      @(negedge aclk);
   endtask

   task automatic idle_inputs();
      en_i = 0; commit_v_i = 0; stall_v_i = 0; stall_reason_i = '0;
      clear_i = 0; snapshot_i = 0; rd_v_i = 0; rd_yumi_i = 0;
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      idle_inputs();
      aresetn = 0;
      model_reset();
      @(negedge aclk);
      aresetn = 1;
   endtask

   task automatic drive(input bit en, input bit cm, input bit st, input int unsigned rs, input int n);
      for (int k = 0; k < n; k++) begin
         en_i = en; commit_v_i = cm; stall_v_i = st; stall_reason_i = 5'(rs);
         tick();
      end
      idle_inputs();
   endtask

   task automatic take_snapshot();
      idle_inputs();
      snapshot_i = 1;
      tick();
      snapshot_i = 0;
   endtask

   // Full read transaction with bounded waits; ok=0 if any bound expired.
   task automatic do_read(input int unsigned a, output logic [cw_lp-1:0] d, output bit ok);
      int n;
      ok = 1; d = '0;
      rd_addr_i = 6'(a); rd_v_i = 1; n = 0;
      while (rd_ready_o !== 1'b1 && n < 8) begin tick(); n++; end
      if (rd_ready_o !== 1'b1) ok = 0;
      tick();
      rd_v_i = 0; n = 0;
      while (rd_v_o !== 1'b1 && n < 8) begin tick(); n++; end
      if (rd_v_o !== 1'b1) ok = 0;
      d = rd_data_o;
      rd_yumi_i = 1;
      tick();
      rd_yumi_i = 0;
   endtask

   task automatic test_reset();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      checks++; if (rd_v_o !== 1'b0) begin errors++; $display("FAIL reset_rd_v got=%b want=0", rd_v_o); end
      checks++; if (rd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got=%b want=1", rd_ready_o); end
      checks++; if (rd_data_o !== '0) begin errors++; $display("FAIL reset_rd_data got=%0d want=0", rd_data_o); end
      checks++; if ({overflow_o, illegal_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b want=00", overflow_o, illegal_o); end
      do_read(33, d, ok);
      checks++; if (!ok || d !== '0) begin errors++; $display("FAIL reset_shadow_cycle got=%0d ok=%0d want=0", d, ok); end
   endtask

   task automatic test_basic();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      drive(1, 0, 1, 3, 5);
      drive(1, 1, 0, 0, 2);
      drive(1, 0, 0, 0, 1);
      take_snapshot();
      do_read(3, d, ok);
      checks++; if (!ok || d !== 8'd5) begin errors++; $display("FAIL basic_bin3 got=%0d want=5", d); end
      do_read(32, d, ok);
      checks++; if (!ok || d !== 8'd2) begin errors++; $display("FAIL basic_commit got=%0d want=2", d); end
      do_read(33, d, ok);
      checks++; if (!ok || d !== 8'd8) begin errors++; $display("FAIL basic_cycle got=%0d want=8", d); end
   endtask

   task automatic test_saturation();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      drive(1, 0, 1, 30, 300);
      take_snapshot();
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b want=1", overflow_o); end
      do_read(30, d, ok);
      checks++; if (!ok || d !== 8'd255) begin errors++; $display("FAIL sat_bin30 got=%0d want=255", d); end
      do_read(33, d, ok);
      checks++; if (!ok || d !== 8'd255) begin errors++; $display("FAIL sat_cycle got=%0d want=255", d); end
      clear_i = 1; tick(); clear_i = 0;
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL sat_clear_ovf got=%b want=0", overflow_o); end
      take_snapshot();
      do_read(30, d, ok);
      checks++; if (!ok || d !== 8'd0) begin errors++; $display("FAIL sat_clear_bin30 got=%0d want=0", d); end
   endtask

   task automatic test_commit_priority();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      drive(1, 1, 1, 25, 4);
      drive(0, 1, 1, 25, 3);
      take_snapshot();
      do_read(32, d, ok);
      checks++; if (!ok || d !== 8'd4) begin errors++; $display("FAIL prio_commit got=%0d want=4", d); end
      do_read(25, d, ok);
      checks++; if (!ok || d !== 8'd0) begin errors++; $display("FAIL prio_bin25 got=%0d want=0", d); end
      do_read(33, d, ok);
      checks++; if (!ok || d !== 8'd4) begin errors++; $display("FAIL prio_cycle got=%0d want=4", d); end
   endtask

   task automatic test_snap_clear();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      drive(1, 0, 1, 7, 7);
      snapshot_i = 1; clear_i = 1; tick(); snapshot_i = 0; clear_i = 0;
      do_read(7, d, ok);
      checks++; if (!ok || d !== 8'd7) begin errors++; $display("FAIL snapclr_shadow got=%0d want=7", d); end
      take_snapshot();
      do_read(7, d, ok);
      checks++; if (!ok || d !== 8'd0) begin errors++; $display("FAIL snapclr_live got=%0d want=0", d); end
   endtask

   task automatic test_resp_hold();
      logic [cw_lp-1:0] d; bit ok;
      logic [cw_lp-1:0] exp_d;
      apply_reset();
      drive(1, 0, 1, 7, 4);
      take_snapshot();
      exp_d = 8'(m_shadow[7]);
      rd_addr_i = 6'd7; rd_v_i = 1; tick(); rd_v_i = 0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rd_v_o !== 1'b1 || rd_ready_o !== 1'b0 || rd_data_o !== exp_d) begin
            errors++;
            $display("FAIL hold_%0d got v=%b rdy=%b data=%0d want v=1 rdy=0 data=%0d",
                     k, rd_v_o, rd_ready_o, rd_data_o, exp_d);
         end
         en_i = 1; stall_v_i = 1; stall_reason_i = 5'd7; snapshot_i = (k == 1);
         tick();
         idle_inputs();
      end
      checks++; if (rd_data_o !== exp_d) begin errors++; $display("FAIL hold_after_snap got=%0d want=%0d", rd_data_o, exp_d); end
      rd_yumi_i = 1; tick(); rd_yumi_i = 0;
      checks++;
      if (rd_ready_o !== 1'b1 || rd_v_o !== 1'b0) begin
         errors++; $display("FAIL hold_release got rdy=%b v=%b want rdy=1 v=0", rd_ready_o, rd_v_o);
      end
      do_read(7, d, ok);
      checks++; if (!ok || d !== 8'(m_shadow[7])) begin errors++; $display("FAIL hold_new_snap got=%0d want=%0d", d, m_shadow[7]); end
   endtask

   task automatic test_illegal();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      drive(1, 0, 1, 31, 1);
      drive(0, 0, 0, 0, 2);
      checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b want=1", illegal_o); end
      take_snapshot();
      do_read(0, d, ok);
      checks++; if (!ok || d !== 8'd1) begin errors++; $display("FAIL illegal_bin0 got=%0d want=1", d); end
      do_read(31, d, ok);
      checks++; if (!ok || d !== 8'd0) begin errors++; $display("FAIL illegal_bin31 got=%0d want=0", d); end
      rd_addr_i = 6'd0; rd_v_i = 1; tick(); rd_v_i = 0;
      checks++; if (rd_v_o !== 1'b1) begin errors++; $display("FAIL illegal_resp got=%b want=1", rd_v_o); end
      #2 aresetn = 0;
      #1;
      checks++;
      if (rd_v_o !== 1'b0 || illegal_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_resp got v=%b ill=%b want v=0 ill=0", rd_v_o, illegal_o);
      end
      model_reset();
      @(negedge aclk);
      aresetn = 1;
   endtask

   task automatic test_random();
      logic [cw_lp-1:0] d; bit ok;
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         en_i           = ($urandom_range(0, 9) != 0);
         commit_v_i     = $urandom_range(0, 1);
         stall_v_i      = $urandom_range(0, 1);
         stall_reason_i = 5'($urandom_range(0, 31));
         clear_i        = ($urandom_range(0, 59) == 0);
         snapshot_i     = ($urandom_range(0, 9) == 0);
         tick();
         checks++;
         if (overflow_o !== m_ovf || illegal_o !== m_ill) begin
            errors++;
            $display("FAIL rand_flags_%0d got ovf=%b ill=%b want ovf=%b ill=%b",
                     k, overflow_o, illegal_o, m_ovf, m_ill);
         end
      end
      idle_inputs();
      take_snapshot();
      for (int a = 0; a < 36; a++) begin
         do_read(a, d, ok);
         checks++;
         if (!ok || d !== 8'((a < 34) ? m_shadow[a] : 0)) begin
            errors++; $display("FAIL rand_addr_%0d got=%0d ok=%0d want=%0d", a, d, ok,
                               (a < 34) ? m_shadow[a] : 0);
         end
      end
      do_read(63, d, ok);
      checks++; if (!ok || d !== '0) begin errors++; $display("FAIL rand_addr_63 got=%0d want=0", d); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_saturation();
      test_commit_priority();
      test_snap_clear();
      test_resp_hold();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
